// File: rtl/exe_stage.sv
// exe_stage: execute stage; ALU or optional iterative divide (EXE_DIV_EN), data-SRAM request, MEM and forwarding buses.
// Latency: 1 cycle for ALU ops; divide holds ready_go low for DIV_ITER+1 cycles, then presents its result.
// Backpressure: EXE_allowin drops while a divide runs or while MEM_allowin is low with a result pending.

// alu: 12-bit one-hot op {lui,sra,srl,sll,xor,or,nor,and,sltu,slt,sub,add}; lui passes src2 through.
// Latency: combinational. Backpressure: none.
// Shift ops use src2[4:0] as the shift amount.
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic [31:0] add_r, sub_r, sra_r;

  assign add_r = alu_src1 + alu_src2;
  assign sub_r = alu_src1 - alu_src2;
  assign sra_r = $signed(alu_src1) >>> alu_src2[4:0];

  always_comb begin
    alu_result = '0;
    if (alu_op[0])  alu_result = alu_result | add_r;
    if (alu_op[1])  alu_result = alu_result | sub_r;
    if (alu_op[2])  alu_result = alu_result | {31'b0, $signed(alu_src1) < $signed(alu_src2)};
    if (alu_op[3])  alu_result = alu_result | {31'b0, alu_src1 < alu_src2};
    if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[8])  alu_result = alu_result | (alu_src1 << alu_src2[4:0]);
    if (alu_op[9])  alu_result = alu_result | (alu_src1 >> alu_src2[4:0]);
    if (alu_op[10]) alu_result = alu_result | sra_r;
    if (alu_op[11]) alu_result = alu_result | alu_src2;
  end
endmodule

module exe_stage #(
  parameter int ID_TO_EXE_W  = 159,
  parameter int EXE_TO_MEM_W = 112,
  parameter int EXE_RF_W     = 39,
  parameter int DIV_ITER     = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ID_TO_EXE_W-1:0]  ID_to_EXE_BUS,
  input  logic                    ID_to_EXE_valid,
  output logic                    EXE_allowin,
  input  logic                    MEM_allowin,
  output logic                    EXE_to_MEM_valid,
  output logic [EXE_TO_MEM_W-1:0] EXE_to_MEM_BUS,
  output logic [EXE_RF_W-1:0]     EXE_RF_BUS,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_we,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);
  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [3:0]  load_op;
    logic        rfrom_mem;
    logic [2:0]  div_op;
  } id_bus_t;

  id_bus_t     id_r;
  logic        exe_valid;
  logic        ready_go;
  logic        res_ready;
  logic [31:0] alu_result;
  logic [31:0] exe_result;
  logic [3:0]  mem_we_sh;

  assign EXE_allowin      = !exe_valid || (ready_go && MEM_allowin);
  assign EXE_to_MEM_valid = exe_valid && ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid <= 1'b0;
    end else if (EXE_allowin) begin
      exe_valid <= ID_to_EXE_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_r <= '0;
    end else if (ID_to_EXE_valid && EXE_allowin) begin
      id_r <= id_bus_t'(ID_to_EXE_BUS);
    end
  end

  alu u_alu (
    .alu_op     (id_r.alu_op),
    .alu_src1   (id_r.src1),
    .alu_src2   (id_r.src2),
    .alu_result (alu_result)
  );

`ifdef EXE_DIV_EN
  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  logic [1:0]       div_state;
  logic [CNT_W-1:0] div_cnt;
  logic [31:0]      quo_r, rem_r, dvs_r;
  logic             neg_q, neg_r, dvs_zero;
  logic             is_div, div_signed;
  logic [31:0]      abs_a, abs_b;
  logic [32:0]      rem_sh;
  logic [33:0]      trial;
  logic             step_ge;
  logic [31:0]      nxt_quo, nxt_rem;

  assign is_div     = id_r.div_op[2];
  assign div_signed = id_r.div_op[1];
  assign abs_a      = (div_signed && id_r.src1[31]) ? -id_r.src1 : id_r.src1;
  assign abs_b      = (div_signed && id_r.src2[31]) ? -id_r.src2 : id_r.src2;

  // Restoring step: quo_r shifts the dividend out MSB-first while quotient bits shift in.
  assign rem_sh  = {rem_r, quo_r[31]};
  assign trial   = {1'b0, rem_sh} - {2'b00, dvs_r};
  assign step_ge = !trial[33];
  assign nxt_rem = step_ge ? trial[31:0] : rem_sh[31:0];
  assign nxt_quo = {quo_r[30:0], step_ge};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
      dvs_r     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvs_zero  <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (exe_valid && is_div) begin
            quo_r     <= abs_a;
            rem_r     <= '0;
            dvs_r     <= abs_b;
            neg_q     <= div_signed && (id_r.src1[31] ^ id_r.src2[31]);
            neg_r     <= div_signed && id_r.src1[31];
            dvs_zero  <= (id_r.src2 == 32'd0);
            div_cnt   <= '0;
            div_state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == CNT_W'(DIV_ITER - 1)) begin
            // Divide-by-zero quotient is forced; the remainder naturally ends up equal to the dividend.
            quo_r     <= dvs_zero ? 32'hFFFF_FFFF : (neg_q ? -nxt_quo : nxt_quo);
            rem_r     <= neg_r ? -nxt_rem : nxt_rem;
            div_state <= DIV_DONE;
          end else begin
            quo_r <= nxt_quo;
            rem_r <= nxt_rem;
          end
        end
        DIV_DONE: begin
          if (EXE_to_MEM_valid && MEM_allowin) div_state <= DIV_IDLE;
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  assign ready_go   = !is_div || (div_state == DIV_DONE);
  assign res_ready  = !(is_div && (div_state != DIV_DONE));
  assign exe_result = is_div ? (id_r.div_op[0] ? rem_r : quo_r) : alu_result;
`else
  localparam int unused_div_iter = DIV_ITER;
  logic unused_div_op;

  assign unused_div_op = ^id_r.div_op;
  assign ready_go      = 1'b1;
  assign res_ready     = 1'b1;
  assign exe_result    = alu_result;
`endif

  assign mem_we_sh       = id_r.mem_we << alu_result[1:0];
  assign data_sram_en    = id_r.mem_en & exe_valid & ready_go & MEM_allowin;
  assign data_sram_we    = mem_we_sh & {4{data_sram_en}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = id_r.rkd_value << {alu_result[1:0], 3'b000};

  assign EXE_to_MEM_BUS = {id_r.pc, id_r.gr_we, id_r.dest, exe_result, alu_result,
                           id_r.mem_en, mem_we_sh, id_r.load_op, id_r.rfrom_mem};
  assign EXE_RF_BUS     = {id_r.dest & {5{id_r.gr_we & exe_valid}}, id_r.rfrom_mem,
                           res_ready, exe_result};
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: reference model at instruction level, monitor pops on each MEM transfer.
module tb_exe_stage;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [158:0] ID_to_EXE_BUS = '0;
  logic         ID_to_EXE_valid = 1'b0;
  logic         EXE_allowin;
  logic         MEM_allowin = 1'b1;
  logic         EXE_to_MEM_valid;
  logic [111:0] EXE_to_MEM_BUS;
  logic [38:0]  EXE_RF_BUS;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

`ifdef EXE_DIV_EN
  localparam bit HAS_DIV = 1'b1;
`else
  localparam bit HAS_DIV = 1'b0;
`endif
  localparam int DIV_LAT = HAS_DIV ? 33 : 0;

  exe_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .ID_to_EXE_BUS    (ID_to_EXE_BUS),
    .ID_to_EXE_valid  (ID_to_EXE_valid),
    .EXE_allowin      (EXE_allowin),
    .MEM_allowin      (MEM_allowin),
    .EXE_to_MEM_valid (EXE_to_MEM_valid),
    .EXE_to_MEM_BUS   (EXE_to_MEM_BUS),
    .EXE_RF_BUS       (EXE_RF_BUS),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [3:0]  load_op;
    logic        rfrom_mem;
    logic [2:0]  div_op;
  } id_t;

  typedef struct packed {
    logic [111:0] bus;
    logic         en;
    logic [3:0]   we;
    logic [31:0]  wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_mem = 1'b0;
  bit   mem_force = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << b[4:0];
      12'h200: return a >> b[4:0];
      12'h400: return sa >>> b[4:0];
      12'h800: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] div_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  function automatic exp_t model(input id_t d);
    exp_t        e;
    logic [31:0] addr, res;
    logic [3:0]  we;
    addr    = alu_ref(d.alu_op, d.src1, d.src2);
    res     = (HAS_DIV && d.div_op[2]) ? div_ref(d.div_op, d.src1, d.src2) : addr;
    we      = d.mem_we << addr[1:0];
    e.bus   = {d.pc, d.gr_we, d.dest, res, addr, d.mem_en, we, d.load_op, d.rfrom_mem};
    e.en    = d.mem_en;
    e.we    = d.mem_en ? we : 4'b0000;
    e.wdata = d.rkd_value << (8 * addr[1:0]);
    return e;
  endfunction

  function automatic id_t mk(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] rkd, input logic [4:0] dest,
                             input logic mem_en, input logic [3:0] mem_we, input logic [2:0] div_op);
    id_t d;
    d.pc = pc; d.alu_op = op; d.src1 = a; d.src2 = b; d.rkd_value = rkd;
    d.gr_we = (dest != 5'd0); d.dest = dest; d.mem_en = mem_en; d.mem_we = mem_we;
    d.load_op = 4'd0; d.rfrom_mem = 1'b0; d.div_op = div_op;
    return d;
  endfunction

  // MEM_allowin is owned by this process; directed tests steer it through mem_force.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      MEM_allowin = rand_mem ? ($urandom_range(0, 3) != 0) : mem_force;
    end
  end

  // Monitor: every accepted MEM transfer must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (resetn && EXE_to_MEM_valid && MEM_allowin) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got bus %h, required no transfer", EXE_to_MEM_BUS);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mem_bus", EXE_to_MEM_BUS, e.bus);
          check("sram_req", {data_sram_en, data_sram_we, data_sram_wdata}, {e.en, e.we, e.wdata});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input id_t d, output int waited);
    bit acc;
    ID_to_EXE_BUS   = d;
    ID_to_EXE_valid = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (waited <= 200) begin
      #2;
      acc = EXE_allowin;
      @(posedge clk);
      if (acc) break;
      waited++;
      @(negedge clk);
    end
    if (acc) begin
      exp_q.push_back(model(d));
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance after %0d cycles, required acceptance", waited);
    end
    @(negedge clk);
    ID_to_EXE_valid = 1'b0;
  endtask

  // Counts cycles from cycle 0 until EXE_to_MEM_valid; returns 3 time units after the edge of that cycle.
  task automatic wait_valid(input string name, input int req);
    int n, lo, rr;
    n = 0; lo = 0; rr = 0;
    while (n < 100) begin
      #3;
      if (EXE_to_MEM_valid) break;
      if (!EXE_allowin) lo++;
      if (!EXE_RF_BUS[32]) rr++;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, req);
    check({name, "_allowin_low"}, lo, req);
    check({name, "_res_ready_low"}, rr, req);
  endtask

  task automatic div_test(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] req_div);
    id_t d;
    int  w;
    d = mk(32'h0000_0200, 12'h000, a, b, 32'd0, 5'd9, 1'b0, 4'd0, op);
    send(d, w);
    wait_valid(name, DIV_LAT);
    check({name, "_value"}, EXE_RF_BUS[31:0], HAS_DIV ? req_div : 32'd0);
    check({name, "_rf_hdr"}, EXE_RF_BUS[38:32], {5'd9, 1'b0, 1'b1});
    @(negedge clk);
  endtask

  initial begin
    id_t d;
    int  w, k, sel;

    #12;
    check("reset_allowin", EXE_allowin, 1'b1);
    check("reset_valid", EXE_to_MEM_valid, 1'b0);
    check("reset_mem_bus", EXE_to_MEM_BUS, 112'd0);
    check("reset_rf_bus", EXE_RF_BUS, 39'h01_0000_0000);
    check("reset_sram", {data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}, 69'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Back-to-back ALU ops.
    send(mk(32'h100, 12'h001, 32'd5, 32'd7, 32'd0, 5'd3, 1'b0, 4'd0, 3'b000), w);
    send(mk(32'h104, 12'h040, 32'hF0, 32'h0F, 32'd0, 5'd4, 1'b0, 4'd0, 3'b000), w);
    check("or_accept_wait", w, 0);
    #3;
    check("or_valid", EXE_to_MEM_valid, 1'b1);
    check("or_result", EXE_to_MEM_BUS[73:42], 32'h0000_00FF);
    @(negedge clk);

    div_test("sdiv_q", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    div_test("sdiv_r", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    div_test("udiv_zero", 3'b100, 32'd100, 32'd0, 32'hFFFF_FFFF);
    div_test("sdiv_ovf_q", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    div_test("sdiv_ovf_r", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Result held while MEM stalls, then a single transfer.
    mem_force = 1'b0;
    send(mk(32'h300, 12'h000, 32'd1000, 32'd7, 32'd0, 5'd4, 1'b0, 4'd0, 3'b100), w);
    wait_valid("hold", DIV_LAT);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #3;
      check("hold_valid", EXE_to_MEM_valid, 1'b1);
      check("hold_value", EXE_RF_BUS[31:0], HAS_DIV ? 32'd142 : 32'd0);
    end
    @(negedge clk);
    mem_force = 1'b1;
    send(mk(32'h304, 12'h001, 32'd1, 32'd2, 32'd0, 5'd5, 1'b0, 4'd0, 3'b000), w);
    check("accept_after_hold", w, 0);

    // Byte store at a misaligned address.
    send(mk(32'h400, 12'h001, 32'h1000, 32'd3, 32'h0000_00AB, 5'd0, 1'b1, 4'b0001, 3'b000), w);
    #3;
    check("store_en", data_sram_en, 1'b1);
    check("store_we", data_sram_we, 4'b1000);
    check("store_wdata", data_sram_wdata, 32'hAB00_0000);
    check("store_addr", data_sram_addr, 32'h0000_1003);
    @(negedge clk);

    // Reset in the middle of a divide.
    send(mk(32'h500, 12'h000, 32'd20, 32'd3, 32'd0, 5'd6, 1'b0, 4'd0, 3'b100), w);
    repeat (11) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_valid", EXE_to_MEM_valid, 1'b0);
    check("midreset_bus", EXE_to_MEM_BUS, 112'd0);
    check("midreset_allowin", EXE_allowin, 1'b1);
    check("midreset_sram_en", data_sram_en, 1'b0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    div_test("post_reset_q", 3'b100, 32'd20, 32'd3, 32'd6);
    div_test("post_reset_r", 3'b101, 32'd20, 32'd3, 32'd2);

    // Randomized traffic with random downstream stalls.
    rand_mem = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 11);
      d.pc        = $urandom;
      d.alu_op    = 12'd1 << k;
      d.src1      = $urandom;
      d.src2      = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
      d.rkd_value = $urandom;
      d.gr_we     = 1'($urandom_range(0, 1));
      d.dest      = 5'($urandom_range(0, 31));
      d.load_op   = 4'($urandom_range(0, 15));
      d.rfrom_mem = 1'($urandom_range(0, 1));
      d.mem_en    = 1'b0;
      d.mem_we    = 4'd0;
      d.div_op    = 3'b000;
      case ($urandom_range(0, 5))
        0: begin
          d.div_op = {1'b1, 2'($urandom_range(0, 3))};
          sel = $urandom_range(0, 7);
          if (sel == 0) d.src2 = 32'd0;
          else if (sel == 1) begin
            d.src1 = 32'h8000_0000;
            d.src2 = 32'hFFFF_FFFF;
          end
        end
        1: begin
          d.mem_en = 1'b1;
          d.alu_op = 12'h001;
          sel = $urandom_range(0, 2);
          d.mem_we = (sel == 0) ? 4'b0001 : ((sel == 1) ? 4'b0011 : 4'b1111);
        end
        default: ;
      endcase
      send(d, w);
    end
    rand_mem = 1'b0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
